// File: rtl/fp_align_pipe.sv
// Two-stage floating-point operand aligner: stage 1 orders the operands by magnitude,
// stage 2 right-shifts the smaller significand and produces guard/round/sticky bits.
module fp_align_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W-1:0] in_a,
  input  logic [EXP_W+MAN_W-1:0] in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W-1:0]     big_exp,
  output logic [MAN_W:0]       big_sig,
  output logic [MAN_W+2:0]     small_sig,
  output logic                 sticky,
  output logic                 swapped
);

  localparam int W     = EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = MAN_W + 3;

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic [EXP_W-1:0] s1_big_exp, s1_diff;
  logic [SIG_W-1:0] s1_big_sig, s1_small_sig;
  logic             s1_swapped;

  logic [EXP_W-1:0] a_exp, b_exp, a_eff, b_eff;
  logic [SIG_W-1:0] a_sig, b_sig;
  logic             swap_c;
  logic [EXP_W-1:0] big_eff_c, small_eff_c;
  logic [SIG_W-1:0] big_sig_c, small_sig_c;

  logic [EXT_W-1:0] ext, shifted;
  logic             sticky_c;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Subnormals (exp == 0) carry no hidden bit and align as exponent 1.
  assign a_exp  = in_a[W-1:MAN_W];
  assign b_exp  = in_b[W-1:MAN_W];
  assign a_eff  = (a_exp == '0) ? EXP_W'(1) : a_exp;
  assign b_eff  = (b_exp == '0) ? EXP_W'(1) : b_exp;
  assign a_sig  = {(a_exp != '0), in_a[MAN_W-1:0]};
  assign b_sig  = {(b_exp != '0), in_b[MAN_W-1:0]};
  assign swap_c = (in_b > in_a);

  always_comb begin
    big_eff_c   = a_eff;
    small_eff_c = b_eff;
    big_sig_c   = a_sig;
    small_sig_c = b_sig;
    if (swap_c) begin
      big_eff_c   = b_eff;
      small_eff_c = a_eff;
      big_sig_c   = b_sig;
      small_sig_c = a_sig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_big_exp   <= '0;
      s1_big_sig   <= '0;
      s1_small_sig <= '0;
      s1_swapped   <= 1'b0;
      s1_diff      <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_big_exp   <= big_eff_c;
        s1_big_sig   <= big_sig_c;
        s1_small_sig <= small_sig_c;
        s1_swapped   <= swap_c;
        s1_diff      <= big_eff_c - small_eff_c;
      end
    end
  end

  assign ext = {s1_small_sig, 2'b00};

  // Shifts of EXT_W or more push every bit into sticky.
  always_comb begin
    shifted  = '0;
    sticky_c = 1'b0;
    if (int'(s1_diff) >= EXT_W) begin
      sticky_c = |s1_small_sig;
    end else begin
      shifted  = ext >> s1_diff;
      sticky_c = |(ext & ~({EXT_W{1'b1}} << s1_diff));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      big_exp   <= '0;
      big_sig   <= '0;
      small_sig <= '0;
      sticky    <= 1'b0;
      swapped   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        big_exp   <= s1_big_exp;
        big_sig   <= s1_big_sig;
        small_sig <= shifted;
        sticky    <= sticky_c;
        swapped   <= s1_swapped;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// Scoreboard bench for fp_align_pipe: directed vectors push expected results,
// a negedge monitor compares every presented output against the queue head.
module tb_fp_align_pipe;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int NV    = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W-1:0] in_a, in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W-1:0]       big_exp;
  logic [MAN_W:0]         big_sig;
  logic [MAN_W+2:0]       small_sig;
  logic                   sticky;
  logic                   swapped;

  typedef struct packed {
    logic [EXP_W-1:0] e;
    logic [MAN_W:0]   bs;
    logic [MAN_W+2:0] ss;
    logic             st;
    logic             sw;
  } res_t;

  res_t                   q[$];
  res_t                   got;
  res_t                   vexp[NV];
  logic [EXP_W+MAN_W-1:0] va[NV];
  logic [EXP_W+MAN_W-1:0] vb[NV];
  int                     checks = 0;
  int                     failures = 0;
  int                     acc;

  fp_align_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_exp(big_exp), .big_sig(big_sig), .small_sig(small_sig),
    .sticky(sticky), .swapped(swapped)
  );

  always #5 clk = ~clk;

  initial begin
    va[0] = 15'h3C00; vb[0] = 15'h3600; vexp[0] = '{5'd15, 11'h400, 13'h0600, 1'b0, 1'b0};
    va[1] = 15'h3600; vb[1] = 15'h3C00; vexp[1] = '{5'd15, 11'h400, 13'h0600, 1'b0, 1'b1};
    va[2] = 15'h3C00; vb[2] = 15'h3C00; vexp[2] = '{5'd15, 11'h400, 13'h1000, 1'b0, 1'b0};
    va[3] = 15'h3C00; vb[3] = 15'h3001; vexp[3] = '{5'd15, 11'h400, 13'h0200, 1'b1, 1'b0};
    va[4] = 15'h7800; vb[4] = 15'h0401; vexp[4] = '{5'd30, 11'h400, 13'h0000, 1'b1, 1'b0};
    va[5] = 15'h0400; vb[5] = 15'h03FF; vexp[5] = '{5'd1,  11'h400, 13'h0FFC, 1'b0, 1'b0};
    va[6] = 15'h3800; vb[6] = 15'h0400; vexp[6] = '{5'd14, 11'h400, 13'h0000, 1'b1, 1'b0};
    va[7] = 15'h3400; vb[7] = 15'h0400; vexp[7] = '{5'd13, 11'h400, 13'h0001, 1'b0, 1'b0};
    va[8] = 15'h0001; vb[8] = 15'h0003; vexp[8] = '{5'd1,  11'h003, 13'h0004, 1'b0, 1'b1};
  end

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      got = '{big_exp, big_sig, small_sig, sticky, swapped};
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got exp=%0d big=%h small=%h st=%b sw=%b with empty queue",
                 got.e, got.bs, got.ss, got.st, got.sw);
      end else begin
        if (got !== q[0]) begin
          failures++;
          $display("FAIL out_data got exp=%0d big=%h small=%h st=%b sw=%b exp exp=%0d big=%h small=%h st=%b sw=%b",
                   got.e, got.bs, got.ss, got.st, got.sw, q[0].e, q[0].bs, q[0].ss, q[0].st, q[0].sw);
        end
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, actual, expected);
    end
  endtask

  task automatic send(input int k);
    int n;
    in_a = va[k];
    in_b = vb[k];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout vector=%0d in_ready=%b exp=1", k, in_ready);
      in_valid = 1'b0;
    end else begin
      q.push_back(vexp[k]);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_a = '0;
    in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_big_exp", big_exp, 0);
    chk("rst_big_sig", big_sig, 0);
    chk("rst_small_sig", small_sig, 0);
    chk("rst_sticky_swapped", {sticky, swapped}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // latency: accepted at edge P, out_valid at P+1
    send(0);
    chk("lat_stage1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_stage2", out_valid, 1);
    @(posedge clk); #1;
    chk("lat_clear", out_valid, 0);

    for (int k = 1; k < NV; k++) send(k);
    drain();

    // backpressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_a = va[acc];
      in_b = vb[acc];
      in_valid = 1'b1;
      if (in_ready) begin
        q.push_back(vexp[acc]);
        acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", in_ready, 1);
    send(2);
    send(3);
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    send(4);
    send(5);
    chk("mid_full_in_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_big_exp", big_exp, 0);
    chk("mid_rst_big_sig", big_sig, 0);
    chk("mid_rst_small_sig", small_sig, 0);
    chk("mid_rst_sticky_swapped", {sticky, swapped}, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", out_valid, 0);
    end

    send(6);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined floating-point operand alignment unit.
- Accepts two unsigned floating-point operands in {exponent, mantissa} format. It orders them by magnitude and right-shifts the smaller significand by the exponent difference, producing guard, round and sticky bits.
- Sits ahead of the significand adder in the systolic-array PE accumulate path.
- Compared with the single-shot combinational aligner, it adds:
  - operand swap
  - subnormal handling
  - shift saturation
  - GRS rounding bits
  - a two-stage valid/ready pipeline with backpressure

Parameters:
EXP_W, 5, exponent field width in bits
MAN_W, 10, stored mantissa (fraction) width in bits; significand is MAN_W+1 bits with the hidden bit

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  unit can accept an operand pair this cycle
in_a  input  EXP_W+MAN_W  operand A, {exp, man}
in_b  input  EXP_W+MAN_W  operand B, {exp, man}
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
big_exp  output  EXP_W  effective exponent of the larger operand
big_sig  output  MAN_W+1  significand of the larger operand, {hidden, man}
small_sig  output  MAN_W+3  aligned smaller significand, {hidden, man, guard, round}
sticky  output  1  OR of all bits of the smaller significand shifted past the round position
swapped  output  1  1 when B was the larger operand

Behaviour:
- Reset (async, rst=1): both stage valid flags clear and all output registers clear to 0. in_ready is 1 once rst is deasserted. A transaction in flight when reset asserts is discarded; out_valid drops immediately.
- Hidden bit and effective exponent:
  - hidden = (exp != 0).
  - eff_exp = (exp == 0) ? 1 : exp, so subnormals align as exponent 1.
- Stage 1 (compare/swap), registered when a transfer happens (in_valid & in_ready):
  - Larger operand = the one with the greater {exp, man}. On exact equality A is larger and swapped=0.
  - Registers: big {eff_exp, sig}, small sig, swapped, and diff = big_eff_exp - small_eff_exp (EXP_W bits, never negative).
- Stage 2 (shift), registered on stage-1 advance:
  - Form ext = {small_sig, 2'b00}, which is MAN_W+3 bits.
  - If diff >= MAN_W+3: small_sig = 0 and sticky = OR(small significand), i.e. saturation.
  - Otherwise: small_sig = ext >> diff and sticky = OR of the diff LSBs of ext that are shifted out.
  - When diff=0, small_sig = ext and sticky = 0.
  - big_exp, big_sig and swapped pass through unchanged.
- Latency: 2 cycles from input acceptance to out_valid, with no stalls. Throughput is 1 pair per cycle.
- Handshake rules:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - The input transfers on in_valid & in_ready; the output transfers on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, every output holds stable and stage 1 holds its contents.
  - in_ready drops only when both stages are full and out_ready=0.
- Simultaneous accept and consume in one cycle is allowed; no bubble is inserted.
- Combinational paths: no path from in_valid to in_ready. The only combinational path is out_ready -> in_ready.
- Data leaving a stage with valid=0 is don't-care, but it must not toggle the outputs while out_valid=1 and the unit is stalled.

Test Plan:
- Basic shift: in_a=0x3C00 (exp15, man0), in_b=0x3600 (exp13, man 0x200) -> after 2 cycles: big_exp=15, big_sig=0x400, small_sig=0x600, sticky=0, swapped=0.
- Swap and tie:
  - in_a=0x3600, in_b=0x3C00 -> same values as the basic case with swapped=1.
  - in_a=in_b=0x3C00 -> swapped=0, small_sig=0x1000, sticky=0.
- Sticky and saturation:
  - in_a=0x3C00, in_b=0x3001 (exp12, man1) -> small_sig=0x200, sticky=1.
  - in_a=0x7800 (exp30), in_b=0x0401 (exp1) -> diff=29 >= 13, so small_sig=0 and sticky=1.
- Subnormal: in_a=0x0400 (exp1, man0), in_b=0x03FF (exp0) -> big_exp=1, big_sig=0x400, small_sig=0xFFC, sticky=0, swapped=0.
- Backpressure:
  - Stream 4 pairs back-to-back with out_ready=0 -> in_ready falls after 2 accepts and outputs hold stable.
  - Then raise out_ready -> all 4 results emerge in order with none lost or duplicated.
- Reset mid-flight: assert rst asynchronously while both stages are full -> out_valid=0 and all outputs 0 immediately. After deassertion in_ready=1 and no stale result appears.
